alu_top: RTL and testbench
==========================

ALU_TOP -- requirements
Module: alu_top

Interface
REQ-001 Parameter OPERAND_WIDTH, default 8, data/operand/result width in bits.
REQ-002 Parameter INST_ADDR_LENGTH, default 2, instruction register-file address width.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rstN  input  1  reset; synchronous, active-high (asserted = 1, sampled on rising clk).
REQ-005 writeEn  input  1  register-file write enable.
REQ-006 writeAddress  input  INST_ADDR_LENGTH  register-file write address: 0 = opcode, 1 = operand A, 2 = operand B, 3 = ignored.
REQ-007 inst  input  OPERAND_WIDTH  write data (opcode or operand).
REQ-008 result  output  OPERAND_WIDTH  ALU result.
REQ-009 error  output  1  invalid operation flag.
REQ-010 zero  output  1  result-is-zero flag.
REQ-011 carry  output  1  unsigned carry/borrow flag.
REQ-012 overflow  output  1  signed overflow / product-overflow flag.

Function
REQ-013 On a rising clk with writeEn=1 and rstN=0, inst shall be stored into the register selected by writeAddress; writes to address 3 shall have no effect.
REQ-014 Outputs shall be combinational from the stored opcode, A, B, HI and LO, so they are valid immediately after the edge that writes the last operand; no result pipeline stage is allowed.
REQ-015 Opcode encodings shall be: 0 ADD, 1 SUB, 2 MULT, 3 DIVIDE, 4 MFHI, 5 MFLO, 6 AND, 7 OR, 8 XOR, 9 NAND, 10 NOR, 11 XNOR, 12 EQUAL, 13 GREATER_THAN, 14 LESS_THAN, 15 ROTATE_LEFT, 16 ROTATE_RIGHT.
REQ-016 ADD: result = (A+B) mod 256; carry = bit 8 of the sum; overflow = signed two's-complement overflow.
REQ-017 SUB: result = (A-B) mod 256; carry = 1 when A<B (borrow); overflow = signed overflow.
REQ-018 MULT: on every rising clk with writeEn=0 and stored opcode = MULT, HI shall capture A*B[15:8] and LO shall capture A*B[7:0]; result = LO; overflow = (HI != 0).
REQ-019 MFHI: result = HI; MFLO: result = LO; HI and LO hold their values under all other opcodes.
REQ-020 DIVIDE: result = floor(A/B), unsigned; B=0 is an error.
REQ-021 Logic opcodes are bitwise on A and B; EQUAL, GREATER_THAN and LESS_THAN are unsigned compares giving 8'h01 if true, else 8'h00.
REQ-022 ROTATE_LEFT/RIGHT: A rotated by B bit positions; B>7 is an error.
REQ-023 Any error condition (opcode >16, divide by zero, rotate amount >7) shall drive error=1, result=0, and zero, carry and overflow all 0.
REQ-024 With no error, zero = (result == 0); carry and overflow are 0 for every opcode other than ADD, SUB and MULT (carry is 0 for MULT).

Reset
REQ-025 While rstN=1 at a rising edge, the opcode, A, B, HI and LO registers shall clear to 0; reset has priority over a simultaneous write.
REQ-026 After reset the outputs shall be result=0, zero=1, error=0, carry=0, overflow=0 (ADD 0+0).
REQ-027 Asserting reset between the MULT load and the capture edge shall leave HI=LO=0.

Configuration
REQ-028 Macro ALU_ROTATE_EN: when defined, opcodes 15/16 behave per REQ-022; when undefined, the rotate logic shall be omitted and opcodes 15/16 shall be treated as invalid (error=1 per REQ-023).

Verification
REQ-029 Load ADD, A=200, B=100 -> result=0x2C, carry=1, overflow=0, zero=0, error=0.
REQ-030 Load SUB, A=0x10, B=0x20 -> result=0xF0, carry=1, zero=0; SUB with A=B=0x55 -> result=0, zero=1.
REQ-031 Load MULT, A=200, B=100, one extra clk -> result=0x20 (LO), overflow=1; then load MFHI -> result=0x4E; load MFLO -> result=0x20.
REQ-032 Load DIVIDE, A=200, B=7 -> result=28; DIVIDE with B=0 -> error=1, result=0.
REQ-033 Load opcode 255 -> error=1; ROTATE_LEFT, B=205 -> error=1; ROTATE_LEFT, A=0x81, B=1 -> result=0x03 (ALU_ROTATE_EN defined).
REQ-034 Load LESS_THAN, A=3, B=9 -> result=0x01; then reset -> all registers 0, result=0, zero=1.

Source files
------------

// File: rtl/alu_top.sv
// Register-file fed ALU with HI/LO product registers and combinational flags.
// Optional rotate opcodes are built only when ALU_ROTATE_EN is defined.
module alu_top #(
    parameter int OPERAND_WIDTH    = 8,
    parameter int INST_ADDR_LENGTH = 2
) (
    input  logic                        clk,
    input  logic                        rstN,
    input  logic                        writeEn,
    input  logic [INST_ADDR_LENGTH-1:0] writeAddress,
    input  logic [OPERAND_WIDTH-1:0]    inst,
    output logic [OPERAND_WIDTH-1:0]    result,
    output logic                        error,
    output logic                        zero,
    output logic                        carry,
    output logic                        overflow
);

    localparam int W = OPERAND_WIDTH;

    typedef logic [W-1:0] word_t;
    typedef logic [INST_ADDR_LENGTH-1:0] addr_t;

    localparam word_t OP_ADD  = word_t'(0);
    localparam word_t OP_SUB  = word_t'(1);
    localparam word_t OP_MULT = word_t'(2);
    localparam word_t OP_DIV  = word_t'(3);
    localparam word_t OP_MFHI = word_t'(4);
    localparam word_t OP_MFLO = word_t'(5);
    localparam word_t OP_AND  = word_t'(6);
    localparam word_t OP_OR   = word_t'(7);
    localparam word_t OP_XOR  = word_t'(8);
    localparam word_t OP_NAND = word_t'(9);
    localparam word_t OP_NOR  = word_t'(10);
    localparam word_t OP_XNOR = word_t'(11);
    localparam word_t OP_EQ   = word_t'(12);
    localparam word_t OP_GT   = word_t'(13);
    localparam word_t OP_LT   = word_t'(14);
`ifdef ALU_ROTATE_EN
    localparam word_t OP_ROTL = word_t'(15);
    localparam word_t OP_ROTR = word_t'(16);
    localparam int    SHW     = $clog2(W);
    localparam word_t ROT_MAX = word_t'(W - 1);
`endif

    localparam addr_t ADDR_OP = addr_t'(0);
    localparam addr_t ADDR_A  = addr_t'(1);
    localparam addr_t ADDR_B  = addr_t'(2);

    word_t op_q, op_d;
    word_t a_q, a_d;
    word_t b_q, b_d;
    word_t hi_q, hi_d;
    word_t lo_q, lo_d;

    logic [2*W-1:0] prod;
    logic [W:0]     sum;
    logic [W:0]     diff;

    word_t res_raw;
    logic  err_raw;
    logic  carry_raw;
    logic  ovf_raw;

`ifdef ALU_ROTATE_EN
    logic [2*W-1:0] rot_l;
    logic [2*W-1:0] rot_r;
    assign rot_l = {a_q, a_q} << b_q[SHW-1:0];
    assign rot_r = {a_q, a_q} >> b_q[SHW-1:0];
`endif

    assign prod = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = {1'b0, a_q} - {1'b0, b_q};

    // Register-file writes; product capture on idle cycles under MULT
    always_comb begin
        op_d = op_q;
        a_d  = a_q;
        b_d  = b_q;
        hi_d = hi_q;
        lo_d = lo_q;
        if (writeEn) begin
            case (writeAddress)
                ADDR_OP: op_d = inst;
                ADDR_A:  a_d  = inst;
                ADDR_B:  b_d  = inst;
                default: ;
            endcase
        end else if (op_q == OP_MULT) begin
            hi_d = prod[2*W-1:W];
            lo_d = prod[W-1:0];
        end
    end

    // State registers; reset wins over a same-edge write
    always_ff @(posedge clk) begin
        if (rstN) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            op_q <= op_d;
            a_q  <= a_d;
            b_q  <= b_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Raw operation result and flags before error masking
    always_comb begin
        res_raw   = '0;
        err_raw   = 1'b0;
        carry_raw = 1'b0;
        ovf_raw   = 1'b0;
        case (op_q)
            OP_ADD: begin
                res_raw   = sum[W-1:0];
                carry_raw = sum[W];
                ovf_raw   = (a_q[W-1] == b_q[W-1]) &&
                            (sum[W-1] != a_q[W-1]);
            end
            OP_SUB: begin
                res_raw   = diff[W-1:0];
                carry_raw = diff[W];
                ovf_raw   = (a_q[W-1] != b_q[W-1]) &&
                            (diff[W-1] != a_q[W-1]);
            end
            OP_MULT: begin
                res_raw = lo_q;
                ovf_raw = |hi_q;
            end
            OP_DIV: begin
                if (b_q == '0) err_raw = 1'b1;
                else           res_raw = a_q / b_q;
            end
            OP_MFHI: res_raw = hi_q;
            OP_MFLO: res_raw = lo_q;
            OP_AND:  res_raw = a_q & b_q;
            OP_OR:   res_raw = a_q | b_q;
            OP_XOR:  res_raw = a_q ^ b_q;
            OP_NAND: res_raw = ~(a_q & b_q);
            OP_NOR:  res_raw = ~(a_q | b_q);
            OP_XNOR: res_raw = ~(a_q ^ b_q);
            OP_EQ:   res_raw = word_t'(a_q == b_q);
            OP_GT:   res_raw = word_t'(a_q > b_q);
            OP_LT:   res_raw = word_t'(a_q < b_q);
`ifdef ALU_ROTATE_EN
            OP_ROTL: begin
                if (b_q > ROT_MAX) err_raw = 1'b1;
                else               res_raw = rot_l[2*W-1:W];
            end
            OP_ROTR: begin
                if (b_q > ROT_MAX) err_raw = 1'b1;
                else               res_raw = rot_r[W-1:0];
            end
`endif
            default: err_raw = 1'b1;
        endcase
    end

    // Any error forces result and all flags low
    always_comb begin
        error    = err_raw;
        result   = err_raw ? '0 : res_raw;
        zero     = !err_raw && (res_raw == '0);
        carry    = !err_raw && carry_raw;
        overflow = !err_raw && ovf_raw;
    end

endmodule

// File: tb/tb_alu_top.sv
// Scoreboard bench for alu_top: expectations queued on load, popped on check.
// Rotate expectations follow ALU_ROTATE_EN.
module tb_alu_top;

    typedef struct packed {
        logic [7:0] res;
        logic       err;
        logic       zero;
        logic       carry;
        logic       ovf;
    } exp_t;

    logic       clk;
    logic       rstN;
    logic       writeEn;
    logic [1:0] writeAddress;
    logic [7:0] inst;
    logic [7:0] result;
    logic       error;
    logic       zero;
    logic       carry;
    logic       overflow;

    exp_t sb[$];
    exp_t e;
    exp_t obs;
    int   passed;
    int   total;

    alu_top #(.OPERAND_WIDTH(8), .INST_ADDR_LENGTH(2)) dut (
        .clk(clk),
        .rstN(rstN),
        .writeEn(writeEn),
        .writeAddress(writeAddress),
        .inst(inst),
        .result(result),
        .error(error),
        .zero(zero),
        .carry(carry),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [7:0] r, input logic er,
                                input logic c, input logic v);
        exp_t x;
        x.res   = er ? 8'h00 : r;
        x.err   = er;
        x.zero  = !er && (r == 8'h00);
        x.carry = c;
        x.ovf   = v;
        return x;
    endfunction

    // Reference for bitwise and compare opcodes
    function automatic exp_t model(input int op, input logic [7:0] a,
                                   input logic [7:0] b);
        logic [7:0] r;
        case (op)
            6:  r = a & b;
            7:  r = a | b;
            8:  r = a ^ b;
            9:  r = ~(a & b);
            10: r = ~(a | b);
            11: r = ~(a ^ b);
            12: r = (a == b) ? 8'h01 : 8'h00;
            13: r = (a > b) ? 8'h01 : 8'h00;
            default: r = (a < b) ? 8'h01 : 8'h00;
        endcase
        return mk(r, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] ad, input logic [7:0] d);
        writeEn      = 1'b1;
        writeAddress = ad;
        inst         = d;
        tick();
        writeEn = 1'b0;
    endtask

    task automatic load3(input logic [7:0] op, input logic [7:0] a,
                         input logic [7:0] b);
        wr(2'd0, op);
        wr(2'd1, a);
        wr(2'd2, b);
    endtask

    task automatic do_reset();
        rstN = 1'b1;
        tick();
        rstN = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        sb.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0));
        e = sb.pop_front();
        obs = {result, error, zero, carry, overflow};
        total++;
        if (obs !== e) $display("FAIL reset_state got %h want %h", obs, e);
        else passed++;
        load3(8'd0, 8'd0, 8'd0);
        rstN = 1'b1; writeEn = 1'b1; writeAddress = 2'd1; inst = 8'h05;
        tick();
        rstN = 1'b0; writeEn = 1'b0;
        sb.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0));
        e = sb.pop_front();
        obs = {result, error, zero, carry, overflow};
        total++;
        if (obs !== e) $display("FAIL reset_priority got %h want %h", obs, e);
        else passed++;
    endtask

    task automatic test_add();
        logic [7:0] av[3] = '{8'd200, 8'h7F, 8'hFF};
        logic [7:0] bv[3] = '{8'd100, 8'h01, 8'h01};
        exp_t       ev[3];
        ev[0] = mk(8'h2C, 1'b0, 1'b1, 1'b0);
        ev[1] = mk(8'h80, 1'b0, 1'b0, 1'b1);
        ev[2] = mk(8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            load3(8'd0, av[i], bv[i]);
            sb.push_back(ev[i]);
            e = sb.pop_front();
            obs = {result, error, zero, carry, overflow};
            total++;
            if (obs !== e) $display("FAIL add_%0d got %h want %h", i, obs, e);
            else passed++;
        end
    endtask

    task automatic test_sub();
        logic [7:0] av[3] = '{8'h10, 8'h55, 8'h80};
        logic [7:0] bv[3] = '{8'h20, 8'h55, 8'h01};
        exp_t       ev[3];
        ev[0] = mk(8'hF0, 1'b0, 1'b1, 1'b0);
        ev[1] = mk(8'h00, 1'b0, 1'b0, 1'b0);
        ev[2] = mk(8'h7F, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            load3(8'd1, av[i], bv[i]);
            sb.push_back(ev[i]);
            e = sb.pop_front();
            obs = {result, error, zero, carry, overflow};
            total++;
            if (obs !== e) $display("FAIL sub_%0d got %h want %h", i, obs, e);
            else passed++;
        end
    endtask

    task automatic test_mult();
        load3(8'd2, 8'd200, 8'd100);
        sb.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0));
        e = sb.pop_front();
        obs = {result, error, zero, carry, overflow};
        total++;
        if (obs !== e) $display("FAIL mult_precap got %h want %h", obs, e);
        else passed++;
        tick();
        sb.push_back(mk(8'h20, 1'b0, 1'b0, 1'b1));
        e = sb.pop_front();
        obs = {result, error, zero, carry, overflow};
        total++;
        if (obs !== e) $display("FAIL mult_cap got %h want %h", obs, e);
        else passed++;
        wr(2'd0, 8'd4);
        sb.push_back(mk(8'h4E, 1'b0, 1'b0, 1'b0));
        e = sb.pop_front();
        obs = {result, error, zero, carry, overflow};
        total++;
        if (obs !== e) $display("FAIL mfhi got %h want %h", obs, e);
        else passed++;
        wr(2'd0, 8'd5);
        sb.push_back(mk(8'h20, 1'b0, 1'b0, 1'b0));
        e = sb.pop_front();
        obs = {result, error, zero, carry, overflow};
        total++;
        if (obs !== e) $display("FAIL mflo got %h want %h", obs, e);
        else passed++;
        load3(8'd2, 8'd3, 8'd5);
        tick();
        sb.push_back(mk(8'h0F, 1'b0, 1'b0, 1'b0));
        e = sb.pop_front();
        obs = {result, error, zero, carry, overflow};
        total++;
        if (obs !== e) $display("FAIL mult_small got %h want %h", obs, e);
        else passed++;
    endtask

    task automatic test_reset_mid_mult();
        load3(8'd2, 8'd200, 8'd100);
        do_reset();
        wr(2'd0, 8'd4);
        sb.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0));
        e = sb.pop_front();
        obs = {result, error, zero, carry, overflow};
        total++;
        if (obs !== e) $display("FAIL rst_mult_hi got %h want %h", obs, e);
        else passed++;
        wr(2'd0, 8'd5);
        sb.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0));
        e = sb.pop_front();
        obs = {result, error, zero, carry, overflow};
        total++;
        if (obs !== e) $display("FAIL rst_mult_lo got %h want %h", obs, e);
        else passed++;
    endtask

    task automatic test_divide();
        logic [7:0] av[3] = '{8'd200, 8'd200, 8'd5};
        logic [7:0] bv[3] = '{8'd7, 8'd0, 8'd9};
        exp_t       ev[3];
        ev[0] = mk(8'd28, 1'b0, 1'b0, 1'b0);
        ev[1] = mk(8'h00, 1'b1, 1'b0, 1'b0);
        ev[2] = mk(8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            load3(8'd3, av[i], bv[i]);
            sb.push_back(ev[i]);
            e = sb.pop_front();
            obs = {result, error, zero, carry, overflow};
            total++;
            if (obs !== e) $display("FAIL div_%0d got %h want %h", i, obs, e);
            else passed++;
        end
    endtask

    task automatic test_logic();
        logic [7:0] a;
        logic [7:0] b;
        for (int op = 6; op <= 14; op++) begin
            for (int k = 0; k < 3; k++) begin
                a = 8'($urandom_range(0, 255));
                b = (k == 2) ? a : 8'($urandom_range(0, 255));
                load3(8'(op), a, b);
                sb.push_back(model(op, a, b));
                e = sb.pop_front();
                obs = {result, error, zero, carry, overflow};
                total++;
                if (obs !== e)
                    $display("FAIL logic_op%0d a=%h b=%h got %h want %h",
                             op, a, b, obs, e);
                else passed++;
            end
        end
    endtask

    task automatic test_compare_reset();
        load3(8'd14, 8'd3, 8'd9);
        sb.push_back(mk(8'h01, 1'b0, 1'b0, 1'b0));
        e = sb.pop_front();
        obs = {result, error, zero, carry, overflow};
        total++;
        if (obs !== e) $display("FAIL lt got %h want %h", obs, e);
        else passed++;
        do_reset();
        sb.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0));
        e = sb.pop_front();
        obs = {result, error, zero, carry, overflow};
        total++;
        if (obs !== e) $display("FAIL lt_reset got %h want %h", obs, e);
        else passed++;
    endtask

    task automatic test_errors();
        logic [7:0] opv[7] = '{8'd255, 8'd17, 8'd15, 8'd15, 8'd16, 8'd15, 8'd16};
        logic [7:0] av[7]  = '{8'd1, 8'd1, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81};
        logic [7:0] bv[7]  = '{8'd1, 8'd1, 8'd205, 8'd1, 8'd1, 8'd7, 8'd8};
        exp_t       ev[7];
        ev[0] = mk(8'h00, 1'b1, 1'b0, 1'b0);
        ev[1] = mk(8'h00, 1'b1, 1'b0, 1'b0);
        ev[2] = mk(8'h00, 1'b1, 1'b0, 1'b0);
`ifdef ALU_ROTATE_EN
        ev[3] = mk(8'h03, 1'b0, 1'b0, 1'b0);
        ev[4] = mk(8'hC0, 1'b0, 1'b0, 1'b0);
        ev[5] = mk(8'hC0, 1'b0, 1'b0, 1'b0);
`else
        ev[3] = mk(8'h00, 1'b1, 1'b0, 1'b0);
        ev[4] = mk(8'h00, 1'b1, 1'b0, 1'b0);
        ev[5] = mk(8'h00, 1'b1, 1'b0, 1'b0);
`endif
        ev[6] = mk(8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            load3(opv[i], av[i], bv[i]);
            sb.push_back(ev[i]);
            e = sb.pop_front();
            obs = {result, error, zero, carry, overflow};
            total++;
            if (obs !== e) $display("FAIL err_rot_%0d got %h want %h", i, obs, e);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        load3(8'd0, 8'd1, 8'd2);
        wr(2'd3, 8'hFF);
        sb.push_back(mk(8'h03, 1'b0, 1'b0, 1'b0));
        e = sb.pop_front();
        obs = {result, error, zero, carry, overflow};
        total++;
        if (obs !== e) $display("FAIL addr3_ignored got %h want %h", obs, e);
        else passed++;
        wr(2'd0, 8'd1);
        sb.push_back(mk(8'hFF, 1'b0, 1'b1, 1'b0));
        e = sb.pop_front();
        obs = {result, error, zero, carry, overflow};
        total++;
        if (obs !== e) $display("FAIL b2b_sub got %h want %h", obs, e);
        else passed++;
        wr(2'd1, 8'h0F);
        sb.push_back(mk(8'h0D, 1'b0, 1'b0, 1'b0));
        e = sb.pop_front();
        obs = {result, error, zero, carry, overflow};
        total++;
        if (obs !== e) $display("FAIL b2b_newa got %h want %h", obs, e);
        else passed++;
    endtask

    initial begin
        passed       = 0;
        total        = 0;
        rstN         = 1'b0;
        writeEn      = 1'b0;
        writeAddress = 2'd0;
        inst         = 8'h00;
        #2;
        test_reset();
        test_add();
        test_sub();
        test_mult();
        test_reset_mid_mult();
        test_divide();
        test_logic();
        test_compare_reset();
        test_errors();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
